dmem_access_ctrl: RTL and testbench

Memory-stage access controller: the initiator that drives the word-wide, async-read/sync-write data memory port on behalf of the pipeline. It accepts byte/halfword/word load and store requests over a valid/ready handshake and performs alignment checking, load extraction with sign/zero extension, and read-modify-write for sub-word stores, since the memory only writes whole words. It returns one response per accepted request.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_lane.sv | 50 +++++
 rtl/dmem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Size and state encodings plus the alignment rule live here so all users agree.
package dmem_pkg;

    localparam int WORD_W  = 32;
    localparam int BYTES_W = WORD_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Illegal size is folded in so the FSM has a single error predicate.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a[0];
            SZ_WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: load extraction with sign/zero extension and
// sub-word store merge into a full memory word (little-endian lanes).
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  size_e       size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_base;
    logic [4:0]  half_base;

    always_comb begin
        byte_base = {addr, 3'b000};
        half_base = {addr[1], 4'b0000};
        byte_sel  = word[byte_base +: 8];
        half_sel  = word[half_base +: 16];
    end

    always_comb begin
        load_ext     = '0;
        store_merged = word;
        case (size)
            SZ_BYTE: begin
                load_ext = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                store_merged[byte_base +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_ext = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
                store_merged[half_base +: 16] = wdata[15:0];
            end
            SZ_WORD: begin
                load_ext     = word;
                store_merged = wdata;
            end
            default: begin
                load_ext     = '0;
                store_merged = word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage access controller: one outstanding load/store at a time against a
// word-wide async-read/sync-write memory, with read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | ready for a request; fields registered on req_valid
// RD    | memory word read into word_q; load result or merged store word formed
// WR    | single-cycle mem_we with the final word
// DONE  | response held until resp_ready
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    state_e      state;
    logic        we_q;
    size_e       size_q;
    logic        uns_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    size_e       req_sz;
    logic [31:0] lane_word;
    logic [31:0] load_ext;
    logic [31:0] store_merged;

    always_comb begin
        req_sz = size_e'(req_size);
    end

    // In RD the memory word is consumed the same cycle it is read, so steer mem_rd
    // straight into the lane logic rather than waiting a cycle for word_q.
    always_comb begin
        lane_word = (state == RD) ? mem_rd : word_q;
    end

    dmem_lane u_lane (
        .word         (lane_word),
        .addr         (addr_lo_q),
        .size         (size_q),
        .uns          (uns_q),
        .wdata        (wdata_q),
        .load_ext     (load_ext),
        .store_merged (store_merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_a      <= '0;
            mem_we     <= 1'b0;
            mem_wd     <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_sz;
                        uns_q     <= req_unsigned;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (is_misaligned(req_sz, req_addr[1:0])) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_a <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_we && req_sz == SZ_WORD) begin
                                state  <= WR;
                                mem_we <= 1'b1;
                                mem_wd <= req_wdata;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    word_q <= mem_rd;
                    if (we_q) begin
                        state  <= WR;
                        mem_we <= 1'b1;
                        mem_wd <= store_merged;
                    end else begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_ext;
                    end
                end
                WR: begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: byte-array reference memory, expected
// responses and memory writes queued at accept, compared by a negedge monitor.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_a        (mem_a),
        .mem_we       (mem_we),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t;
    } rsp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          t;
    } wr_t;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  ref_b[256];
    logic [31:0] tb_mem[64];
    logic        mem_init;
    logic        rr_rand = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return (32'h9E3779B9 * 32'(i + 1)) ^ (32'(i) << 20);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
        end else if (mem_we) begin
            tb_mem[mem_a[7:2]] <= mem_wd;
        end
    end

    assign mem_rd = tb_mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (rr_rand) begin
            #1 resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference behaviour at accept in cycle cyc: plain byte-array arithmetic.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int          n;
        int          a;
        int          b;
        logic [31:0] v;
        rsp_t        r;
        wr_t         w;
        n = 1 << sz;
        a = int'(addr[7:0]);
        if (sz == 2'd3 || (a % n) != 0) begin
            r = '{rdata: 32'd0, err: 1'b1, t: cyc + 1};
        end else if (!we) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v + (32'(ref_b[a + i]) << (8 * i));
            if (!uns && n < 4 && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
            r = '{rdata: v, err: 1'b0, t: cyc + 2};
        end else begin
            for (int i = 0; i < n; i++) ref_b[a + i] = 8'(wd >> (8 * i));
            b = a - (a % 4);
            w.a = addr - (addr % 4);
            w.d = {ref_b[b + 3], ref_b[b + 2], ref_b[b + 1], ref_b[b]};
            w.t = (n == 4) ? cyc + 1 : cyc + 2;
            wr_q.push_back(w);
            r = '{rdata: 32'd0, err: 1'b0, t: (n == 4) ? cyc + 2 : cyc + 3};
        end
        rsp_q.push_back(r);
    endtask

    // Called just after a rising edge; holds req_valid until the controller is idle.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int waited;
        waited = 0;
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wd;
        while (!req_ready) begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 200) begin
                fail_now("accept_timeout");
                req_valid = 1'b0;
                return;
            end
        end
        model(we, sz, uns, addr, wd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (rsp_q.size() != 0 || wr_q.size() != 0 || !req_ready) begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 500) begin
                fail_now("idle_timeout");
                return;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_err"},   32'(resp_err), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_mem_we"},     32'(mem_we), 32'd0);
        chk({tag, "_mem_a"},      mem_a, 32'd0);
        chk({tag, "_mem_wd"},     mem_wd, 32'd0);
    endtask

    rsp_t mon_r;
    wr_t  mon_w;
    bit   in_resp = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_resp = 1'b0;
        end else begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    fail_now("unexpected_mem_we");
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_addr", mem_a, mon_w.a);
                    chk("wr_data", mem_wd, mon_w.d);
                    chk("wr_cycle", 32'(cyc), 32'(mon_w.t));
                end
            end
            if (resp_valid) begin
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    mon_r = rsp_q[0];
                    if (!in_resp) begin
                        chk("resp_cycle", 32'(cyc), 32'(mon_r.t));
                        in_resp = 1'b1;
                    end
                    chk("resp_rdata", resp_rdata, mon_r.rdata);
                    chk("resp_err", 32'(resp_err), 32'(mon_r.err));
                    if (resp_ready) begin
                        void'(rsp_q.pop_front());
                        in_resp = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] iw;
        logic [1:0]  sz;
        logic [31:0] addr;
        int          r;

        reset_n = 1'b0;
        mem_init = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        resp_ready = 1'b1;
        for (int w = 0; w < 64; w++) begin
            iw = init_word(w);
            for (int k = 0; k < 4; k++) ref_b[4 * w + k] = iw[8 * k +: 8];
        end

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        mem_init = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases from the access-pattern list.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
        wait_idle();
        chk("mem_byte_merge", tb_mem[8], 32'h1122AA44);
        issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h8001FFFF);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234);
        wait_idle();
        chk("mem_half_merge", tb_mem[8], 32'h1234FFFF);
        issue(1'b0, 2'd1, 1'b0, 32'h23, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h26, 32'h12345678);
        issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
        wait_idle();

        // Backpressure: five DONE cycles with resp_ready low and a request waiting.
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        fork
            issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055);
            begin
                repeat (6) @(posedge clk);
                #1;
                resp_ready = 1'b1;
                @(posedge clk);
                #1;
                chk("ready_after_hs", 32'(req_ready), 32'd1);
            end
        join
        wait_idle();

        // Asynchronous reset while the word store sits in WR.
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        req_addr = 32'h30;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("we_in_wr", 32'(mem_we), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h32, 32'h0000007E);
        issue(1'b0, 2'd0, 1'b0, 32'h32, 32'h0);
        wait_idle();

        // Randomized traffic with random response backpressure.
        rr_rand = 1'b1;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            sz = (r < 9) ? 2'(r % 3) : 2'd3;
            addr = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0)
                addr = addr & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rr_rand = 1'b0;
        @(posedge clk);
        #2;
        resp_ready = 1'b1;
        wait_idle();
        chk("resp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
